// File: rtl/div_unit.sv
// Iterative signed divider (restoring, one quotient bit per clock).
// The quotient goes to LoOut and the remainder to HiOut; Done pulses once per request.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

  stateT            state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divisor;
  logic             signQ;
  logic             signR;
  logic             zeroFlag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // The result of the unsigned negation is the magnitude, so |-2^(W-1)| = 2^(W-1) stays exact.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] applySign(input logic neg, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = neg ? WIDTH'(-v) : v;
    return r;
  endfunction

  always_comb begin
    shifted = {remReg, quoReg[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      counter  <= '0;
      remReg   <= '0;
      quoReg   <= '0;
      divisor  <= '0;
      signQ    <= 1'b0;
      signR    <= 1'b0;
      zeroFlag <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      DivZero  <= 1'b0;
      HiOut    <= '0;
      LoOut    <= '0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            Busy <= 1'b1;
            if (B == '0) begin
              zeroFlag <= 1'b1;
              state    <= DONE;
            end else begin
              zeroFlag <= 1'b0;
              quoReg   <= magnitude(A);
              divisor  <= magnitude(B);
              signQ    <= A[WIDTH-1] ^ B[WIDTH-1];
              signR    <= A[WIDTH-1];
              remReg   <= '0;
              counter  <= '0;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          // A non-negative trial difference means the divisor fits: keep it and emit a 1.
          if (!diff[WIDTH]) begin
            remReg <= diff[WIDTH-1:0];
            quoReg <= {quoReg[WIDTH-2:0], 1'b1};
          end else begin
            remReg <= shifted[WIDTH-1:0];
            quoReg <= {quoReg[WIDTH-2:0], 1'b0};
          end
          counter <= counter + 1'b1;
          if (counter == LAST_ITER) state <= FIX;
        end
        FIX: begin
          LoOut <= applySign(signQ, quoReg);
          HiOut <= applySign(signR, remReg);
          state <= DONE;
        end
        DONE: begin
          Done     <= 1'b1;
          DivZero  <= zeroFlag;
          zeroFlag <= 1'b0;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus reset, re-start and held-Start sequences.
module tb_div_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] HiOut;
  logic [31:0] LoOut;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .HiOut(HiOut), .LoOut(LoOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expLo;
    logic [31:0] expHi;
    logic        expDz;
    int          expLat;
  } vecT;

  vecT vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pulses Start for one edge, scrambles the operands, then counts edges until Done.
  task automatic runDiv(input logic [31:0] a, input logic [31:0] b, output int lat);
    Start = 1'b1;
    A = a;
    B = b;
    tick();
    Start = 1'b0;
    A = $urandom;
    B = $urandom | 32'h1;
    lat = 0;
    while (lat < 100) begin
      tick();
      lat++;
      if (Done) break;
    end
    if (!Done) lat = -1;
  endtask

  initial begin
    int lat;
    int doneCnt;
    int firstDone;
    int secondDone;

    vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34};
    vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 34};
    vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 34};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34};
    vecs[5]  = '{32'd3,        32'd10,       32'd0,        32'd3,        1'b0, 34};
    vecs[6]  = '{32'd5,        32'd0,        32'd0,        32'd3,        1'b1, 1};
    vecs[7]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, 34};
    vecs[8]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, 34};
    vecs[9]  = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0, 34};
    vecs[10] = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 34};

    Reset = 1'b1;
    Start = 1'b0;
    A = '0;
    B = '0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check("reset Busy", {31'd0, Busy}, 32'd0);
    check("reset Done", {31'd0, Done}, 32'd0);
    check("reset DivZero", {31'd0, DivZero}, 32'd0);
    check("reset LoOut", LoOut, 32'd0);
    check("reset HiOut", HiOut, 32'd0);

    for (int i = 0; i < 11; i++) begin
      runDiv(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
      check($sformatf("vec%0d LoOut", i), LoOut, vecs[i].expLo);
      check($sformatf("vec%0d HiOut", i), HiOut, vecs[i].expHi);
      check($sformatf("vec%0d DivZero", i), {31'd0, DivZero}, {31'd0, vecs[i].expDz});
      check($sformatf("vec%0d Busy at Done", i), {31'd0, Busy}, 32'd0);
      tick();
      check($sformatf("vec%0d Done one cycle", i), {31'd0, Done}, 32'd0);
      check($sformatf("vec%0d DivZero one cycle", i), {31'd0, DivZero}, 32'd0);
    end

    // Reset in the middle of CALC clears everything at once and suppresses Done.
    Start = 1'b1;
    A = 32'd100;
    B = 32'd7;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    check("midcalc Busy before reset", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    #1;
    check("midcalc reset Busy", {31'd0, Busy}, 32'd0);
    check("midcalc reset LoOut", LoOut, 32'd0);
    check("midcalc reset HiOut", HiOut, 32'd0);
    tick();
    Reset = 1'b0;
    doneCnt = 0;
    repeat (40) begin
      tick();
      if (Done) doneCnt++;
    end
    check("midcalc no Done", doneCnt, 0);

    // Start re-pulsed during the divide must not restart it.
    Start = 1'b1;
    A = 32'd50;
    B = 32'd6;
    tick();
    Start = 1'b0;
    doneCnt = 0;
    firstDone = -1;
    for (int e = 1; e <= 45; e++) begin
      if (e == 5 || e == 20) begin
        Start = 1'b1;
        A = 32'd1000;
        B = 32'd3;
      end
      tick();
      Start = 1'b0;
      if (Done) begin
        doneCnt++;
        if (firstDone < 0) begin
          firstDone = e;
          check("repulse LoOut", LoOut, 32'd8);
          check("repulse HiOut", HiOut, 32'd2);
        end
      end
    end
    check("repulse Done count", doneCnt, 1);
    check("repulse Done edge", firstDone, 34);

    // Start held high throughout: ignored in DONE, taken in the following IDLE cycle.
    Start = 1'b1;
    A = 32'd100;
    B = 32'd7;
    tick();
    A = 32'd20;
    B = 32'd3;
    firstDone = -1;
    secondDone = -1;
    for (int e = 1; e <= 80; e++) begin
      tick();
      if (Done && firstDone < 0) begin
        firstDone = e;
        check("held first LoOut", LoOut, 32'd14);
        check("held first HiOut", HiOut, 32'd2);
      end else if (Done && secondDone < 0) begin
        secondDone = e;
        check("held second LoOut", LoOut, 32'd6);
        check("held second HiOut", HiOut, 32'd2);
        Start = 1'b0;
      end
      if (e == 35) check("held Busy after restart", {31'd0, Busy}, 32'd1);
    end
    Start = 1'b0;
    check("held first Done edge", firstDone, 34);
    check("held second Done edge", secondDone, 69);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
